// File: rtl/qbuf_pingpong.sv
// Ping-pong frame buffer: two banks, writer FSM with format check, oldest-first read.
// Optional pad-row checking is enabled with `define QBUF_PAD_CHECK_EN.
module qbuf_pingpong #(
  parameter int W   = 32,
  parameter int H   = 32,
  parameter int PAD = 4,
  parameter int AW  = 10
) (
  input  logic                 clk_in_100,
  input  logic                 arst_n,
  input  logic                 in_valid,
  input  logic signed [7:0]    in_pixel,
  input  logic                 in_line_last,
  input  logic                 in_frame_last,
  input  logic                 in_is_pad,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic signed [7:0]    rd_data,
  output logic                 frame_ready,
  output logic                 rd_bank,
  input  logic                 rd_release,
  output logic [15:0]          frames_cnt,
  output logic [7:0]           drop_cnt,
  output logic [7:0]           err_cnt,
  output logic                 err_fmt
);

  localparam int N = W * H;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;

  localparam logic [1:0] B_FREE = 2'd0;
  localparam logic [1:0] B_FILL = 2'd1;
  localparam logic [1:0] B_FULL = 2'd2;

  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [1:0]    st;
  logic [1:0]    bst [2];
  logic          wb;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] col;
  logic [AW-1:0] row;
  logic          bad_q;
  logic          ovf;

  logic [7:0]    mem0 [N];
  logic [7:0]    mem1 [N];

  logic          any_free;
  logic          sel;
  logic          start;
  logic          act;
  logic          cur_bank;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] cur_col;
  logic [AW-1:0] cur_row;
  logic          cur_ovf;
  logic          last_addr;
  logic          pad_bad;
  logic          s_bad;
  logic          fbad;
  logic          commit;
  logic          commit_good;
  logic          we;
  logic          rel;
  logic          other_full;

  // Reset asserts immediately, releases on a clock edge.
  always_ff @(posedge clk_in_100 or negedge arst_n)
    if (!arst_n) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};

  assign rst_n = rst_sync[1];

  assign any_free  = (bst[0] == B_FREE) || (bst[1] == B_FREE);
  assign sel       = (bst[0] == B_FREE) ? 1'b0 : 1'b1;
  assign start     = (st == S_IDLE) && in_valid && any_free;
  assign act       = start || ((st == S_WRITE) && in_valid);
  assign cur_bank  = (st == S_IDLE) ? sel : wb;
  assign cur_addr  = (st == S_IDLE) ? '0 : wr_addr;
  assign cur_col   = (st == S_IDLE) ? '0 : col;
  assign cur_row   = (st == S_IDLE) ? '0 : row;
  assign cur_ovf   = (st == S_WRITE) && ovf;
  assign last_addr = (cur_addr == AW'(N - 1));

`ifdef QBUF_PAD_CHECK_EN
  logic pad_row;
  assign pad_row = (cur_row < AW'(PAD)) || (cur_row >= AW'(H - PAD));
  assign pad_bad = (in_is_pad != pad_row) || (in_is_pad && (in_pixel != 8'sd0));
`else
  logic unused_pad;
  assign unused_pad = in_is_pad;
  assign pad_bad    = 1'b0;
`endif

  assign s_bad = (in_line_last != (cur_col == AW'(W - 1)))
              || (in_frame_last != last_addr)
              || cur_ovf
              || pad_bad;

  assign fbad        = ((st == S_WRITE) && bad_q) || s_bad;
  assign commit      = act && in_frame_last;
  assign commit_good = commit && !fbad;
  assign we          = act && !cur_ovf;

  assign frame_ready = (bst[0] == B_FULL) || (bst[1] == B_FULL);
  assign rel         = rd_release && frame_ready;
  assign other_full  = (bst[~rd_bank] == B_FULL)
                    || (commit_good && (cur_bank == ~rd_bank));

  // Writer FSM with address, column and row tracking.
  always_ff @(posedge clk_in_100 or negedge rst_n)
    if (!rst_n) begin
      st      <= S_IDLE;
      wb      <= 1'b0;
      wr_addr <= '0;
      col     <= '0;
      row     <= '0;
      bad_q   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      unique case (st)
        S_IDLE: if (in_valid) begin
          if (!any_free) begin
            if (!in_frame_last) st <= S_DROP;
          end else begin
            wb <= sel;
            if (!in_frame_last) begin
              st    <= S_WRITE;
              bad_q <= s_bad;
              ovf   <= last_addr;
              if (!last_addr) begin
                wr_addr <= cur_addr + 1'b1;
                if (cur_col == AW'(W - 1)) begin
                  col <= '0;
                  row <= cur_row + 1'b1;
                end else begin
                  col <= cur_col + 1'b1;
                end
              end
            end
          end
        end
        S_WRITE: if (in_valid) begin
          if (in_frame_last) begin
            st      <= S_IDLE;
            wr_addr <= '0;
            col     <= '0;
            row     <= '0;
            bad_q   <= 1'b0;
            ovf     <= 1'b0;
          end else begin
            bad_q <= bad_q | s_bad;
            if (!ovf) begin
              ovf <= last_addr;
              if (!last_addr) begin
                wr_addr <= cur_addr + 1'b1;
                if (cur_col == AW'(W - 1)) begin
                  col <= '0;
                  row <= cur_row + 1'b1;
                end else begin
                  col <= cur_col + 1'b1;
                end
              end
            end
          end
        end
        S_DROP: if (in_valid && in_frame_last) st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end

  // Bank lifecycle: release, claim and commit may all land in one cycle.
  always_ff @(posedge clk_in_100 or negedge rst_n)
    if (!rst_n) begin
      bst[0] <= B_FREE;
      bst[1] <= B_FREE;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (rel && (rd_bank == 1'(i)))      bst[i] <= B_FREE;
        if (start && (sel == 1'(i)))        bst[i] <= B_FILL;
        if (commit && (cur_bank == 1'(i)))  bst[i] <= commit_good ? B_FULL : B_FREE;
      end
    end

  // Read pointer follows commit order: oldest FULL bank first.
  always_ff @(posedge clk_in_100 or negedge rst_n)
    if (!rst_n)                            rd_bank <= 1'b0;
    else if (rel)                          rd_bank <= other_full ? ~rd_bank : rd_bank;
    else if (commit_good && !frame_ready)  rd_bank <= cur_bank;

  // Status counters.
  always_ff @(posedge clk_in_100 or negedge rst_n)
    if (!rst_n) begin
      frames_cnt <= '0;
      drop_cnt   <= '0;
      err_cnt    <= '0;
      err_fmt    <= 1'b0;
    end else begin
      if (commit_good) frames_cnt <= frames_cnt + 1'b1;
      if (commit && fbad) begin
        err_fmt <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
      end
      if (in_valid && in_frame_last && (((st == S_IDLE) && !any_free) || (st == S_DROP)))
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end

  // Sample storage; contents survive reset.
  always_ff @(posedge clk_in_100)
    if (we) begin
      if (cur_bank) mem1[cur_addr] <= in_pixel;
      else          mem0[cur_addr] <= in_pixel;
    end

  // Registered read port, gated to zero when nothing is committed.
  always_ff @(posedge clk_in_100 or negedge rst_n)
    if (!rst_n) rd_data <= '0;
    else if (rd_en) begin
      if (!frame_ready)  rd_data <= '0;
      else if (rd_bank)  rd_data <= mem1[rd_addr];
      else               rd_data <= mem0[rd_addr];
    end

endmodule

// File: tb/tb_qbuf_pingpong.sv
// Scenario bench for qbuf_pingpong with a read-data scoreboard queue.
// Pad expectations follow QBUF_PAD_CHECK_EN.
module tb_qbuf_pingpong;

  localparam int W   = 32;
  localparam int H   = 32;
  localparam int PAD = 4;
  localparam int AW  = 10;
  localparam int N   = W * H;
`ifdef QBUF_PAD_CHECK_EN
  localparam bit PADEN = 1'b1;
`else
  localparam bit PADEN = 1'b0;
`endif

  logic              clk_in_100 = 1'b0;
  logic              arst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [7:0] in_pixel = '0;
  logic              in_line_last = 1'b0;
  logic              in_frame_last = 1'b0;
  logic              in_is_pad = 1'b0;
  logic              rd_en = 1'b0;
  logic [AW-1:0]     rd_addr = '0;
  logic signed [7:0] rd_data;
  logic              frame_ready;
  logic              rd_bank;
  logic              rd_release = 1'b0;
  logic [15:0]       frames_cnt;
  logic [7:0]        drop_cnt;
  logic [7:0]        err_cnt;
  logic              err_fmt;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  qbuf_pingpong #(.W(W), .H(H), .PAD(PAD), .AW(AW)) dut (
    .clk_in_100(clk_in_100), .arst_n(arst_n),
    .in_valid(in_valid), .in_pixel(in_pixel),
    .in_line_last(in_line_last), .in_frame_last(in_frame_last),
    .in_is_pad(in_is_pad), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .frame_ready(frame_ready), .rd_bank(rd_bank),
    .rd_release(rd_release), .frames_cnt(frames_cnt),
    .drop_cnt(drop_cnt), .err_cnt(err_cnt), .err_fmt(err_fmt)
  );

  always #5 clk_in_100 = ~clk_in_100;

  function automatic logic [7:0] pix(input int a, input int bad_row);
    int r;
    r = a / W;
    if (r == bad_row && (a % W) == 0) return 8'd5;
    if (PADEN && (r < PAD || r >= H - PAD)) return 8'd0;
    return 8'(a);
  endfunction

  task automatic send_frame(input int ll_err, input int pad_err_row,
                            input bit rel_last, input int count);
    for (int a = 0; a < count; a++) begin
      @(negedge clk_in_100);
      in_valid      = 1'b1;
      in_pixel      = pix(a, pad_err_row);
      in_line_last  = ((a % W) == W - 1) || (a == ll_err);
      in_frame_last = (a == N - 1);
      in_is_pad     = (a / W < PAD) || (a / W >= H - PAD);
      rd_release    = rel_last && (a == N - 1);
    end
    @(negedge clk_in_100);
    in_valid = 1'b0; in_line_last = 1'b0; in_frame_last = 1'b0;
    in_is_pad = 1'b0; rd_release = 1'b0; in_pixel = '0;
  endtask

  task automatic send_single();
    @(negedge clk_in_100);
    in_valid = 1'b1; in_pixel = '0; in_line_last = 1'b0;
    in_frame_last = 1'b1; in_is_pad = 1'b1;
    @(negedge clk_in_100);
    in_valid = 1'b0; in_frame_last = 1'b0; in_is_pad = 1'b0;
  endtask

  task automatic drive_read(input int addr, input logic [7:0] exp);
    @(negedge clk_in_100);
    rd_en = 1'b1; rd_addr = AW'(addr);
    exp_q.push_back(exp);
    @(negedge clk_in_100);
    rd_en = 1'b0;
  endtask

  task automatic release_pulse();
    @(negedge clk_in_100);
    rd_release = 1'b1;
    @(negedge clk_in_100);
    rd_release = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_in_100);
    arst_n = 1'b0;
    repeat (2) @(negedge clk_in_100);
    arst_n = 1'b1;
    repeat (3) @(negedge clk_in_100);
  endtask

  task automatic test_reset();
    @(negedge clk_in_100);
    arst_n = 1'b0;
    repeat (2) @(negedge clk_in_100);
    checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b exp 0", frame_ready); end
    checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL rst_bank got %0b exp 0", rd_bank); end
    checks++; if (rd_data !== 8'sd0) begin errors++; $display("FAIL rst_data got %0d exp 0", rd_data); end
    checks++; if (frames_cnt !== 16'd0) begin errors++; $display("FAIL rst_frames got %0d exp 0", frames_cnt); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_drop got %0d exp 0", drop_cnt); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err got %0d exp 0", err_cnt); end
    checks++; if (err_fmt !== 1'b0) begin errors++; $display("FAIL rst_errfmt got %0b exp 0", err_fmt); end
    arst_n = 1'b1;
    repeat (3) @(negedge clk_in_100);
  endtask

  task automatic test_single_frame();
    do_reset();
    send_frame(-1, -1, 1'b0, N);
    checks++; if (frames_cnt !== 16'd1) begin errors++; $display("FAIL s1_frames got %0d exp 1", frames_cnt); end
    checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL s1_ready got %0b exp 1", frame_ready); end
    checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL s1_bank got %0b exp 0", rd_bank); end
    drive_read(37, pix(37, -1));
    exp_v = exp_q.pop_front();
    checks++; if (rd_data !== exp_v) begin errors++; $display("FAIL s1_rd37 got %0d exp %0d", rd_data, exp_v); end
    drive_read(500, pix(500, -1));
    exp_v = exp_q.pop_front();
    checks++; if (rd_data !== exp_v) begin errors++; $display("FAIL s1_rd500 got %0d exp %0d", rd_data, exp_v); end
  endtask

  task automatic test_three_frames();
    do_reset();
    send_frame(-1, -1, 1'b0, N);
    send_frame(-1, -1, 1'b0, N);
    send_frame(-1, -1, 1'b0, N);
    checks++; if (frames_cnt !== 16'd2) begin errors++; $display("FAIL s2_frames got %0d exp 2", frames_cnt); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL s2_drop got %0d exp 1", drop_cnt); end
    checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL s2_bank got %0b exp 0", rd_bank); end
    for (int k = 0; k < 260; k++) send_single();
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL s2_dropsat got %0d exp 255", drop_cnt); end
    release_pulse();
    checks++; if (rd_bank !== 1'b1) begin errors++; $display("FAIL s2_relbank got %0b exp 1", rd_bank); end
    checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL s2_relready got %0b exp 1", frame_ready); end
    release_pulse();
    checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL s2_empty got %0b exp 0", frame_ready); end
    drive_read(100, 8'd0);
    exp_v = exp_q.pop_front();
    checks++; if (rd_data !== exp_v) begin errors++; $display("FAIL s2_rdempty got %0d exp %0d", rd_data, exp_v); end
  endtask

  task automatic test_bad_line();
    do_reset();
    send_frame(5 * W + 30, -1, 1'b0, N);
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL s3_err got %0d exp 1", err_cnt); end
    checks++; if (err_fmt !== 1'b1) begin errors++; $display("FAIL s3_errfmt got %0b exp 1", err_fmt); end
    checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL s3_ready got %0b exp 0", frame_ready); end
    checks++; if (frames_cnt !== 16'd0) begin errors++; $display("FAIL s3_frames got %0d exp 0", frames_cnt); end
    send_frame(-1, -1, 1'b0, N);
    checks++; if (frames_cnt !== 16'd1) begin errors++; $display("FAIL s3_good got %0d exp 1", frames_cnt); end
    checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL s3_bank got %0b exp 0", rd_bank); end
    send_single();
    checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL s3_single got %0d exp 2", err_cnt); end
  endtask

  task automatic test_release_commit();
    do_reset();
    send_frame(-1, -1, 1'b0, N);
    send_frame(-1, -1, 1'b1, N);
    checks++; if (rd_bank !== 1'b1) begin errors++; $display("FAIL s4_bank got %0b exp 1", rd_bank); end
    checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL s4_ready got %0b exp 1", frame_ready); end
    checks++; if (frames_cnt !== 16'd2) begin errors++; $display("FAIL s4_frames got %0d exp 2", frames_cnt); end
    release_pulse();
    checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL s4_empty got %0b exp 0", frame_ready); end
    send_frame(-1, -1, 1'b0, N);
    checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL s4_reuse got %0b exp 0", rd_bank); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_frame(-1, -1, 1'b0, 500);
    do_reset();
    send_frame(-1, -1, 1'b0, N);
    checks++; if (frames_cnt !== 16'd1) begin errors++; $display("FAIL s5_frames got %0d exp 1", frames_cnt); end
    checks++; if (rd_bank !== 1'b0) begin errors++; $display("FAIL s5_bank got %0b exp 0", rd_bank); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL s5_drop got %0d exp 0", drop_cnt); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL s5_err got %0d exp 0", err_cnt); end
  endtask

  task automatic test_pad();
    logic [15:0] ef;
    logic [7:0]  ee;
    ef = PADEN ? 16'd0 : 16'd1;
    ee = PADEN ? 8'd1 : 8'd0;
    do_reset();
    send_frame(-1, 2, 1'b0, N);
    checks++; if (frames_cnt !== ef) begin errors++; $display("FAIL s6_frames got %0d exp %0d", frames_cnt, ef); end
    checks++; if (err_cnt !== ee) begin errors++; $display("FAIL s6_err got %0d exp %0d", err_cnt, ee); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_three_frames();
    test_bad_line();
    test_release_commit();
    test_reset_mid_frame();
    test_pad();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
